// File: rtl/mm_pkg.sv
// Shared types and sizing for the mm operand source (mm_src and its FIFO).
package mm_pkg;
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, DONE} mm_src_state_t;

  localparam int unsigned SRC_FIFO_DEPTH = 3;
  localparam int unsigned SRC_FIFO_CNT_W = $clog2(SRC_FIFO_DEPTH + 1);
  localparam int unsigned SRC_FIFO_PTR_W = (SRC_FIFO_DEPTH > 1) ? $clog2(SRC_FIFO_DEPTH) : 1;
endpackage

// File: rtl/mm_src_fifo.sv
// Small synchronous FIFO holding {last,data} beats between the operand RAM and the streams.
module mm_src_fifo
  import mm_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic [SRC_FIFO_CNT_W-1:0] count
);
  logic [W-1:0]              mem [SRC_FIFO_DEPTH];
  logic [SRC_FIFO_PTR_W-1:0] rd_ptr;
  logic [SRC_FIFO_PTR_W-1:0] wr_ptr;

  function automatic logic [SRC_FIFO_PTR_W-1:0] ptr_inc(input logic [SRC_FIFO_PTR_W-1:0] p);
    return (p == SRC_FIFO_PTR_W'(SRC_FIFO_DEPTH - 1)) ? '0 : p + SRC_FIFO_PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < SRC_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + SRC_FIFO_CNT_W'(1);
        2'b01:   count <= count - SRC_FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb head = mem[rd_ptr];
endmodule

// File: rtl/mm_src.sv
// Streams operand matrices A then B from the operand RAM onto mm's in_A / in_B ports.
// Optional MM_SRC_STALL_CNT_EN adds per-channel saturating stall counters.
module mm_src
  import mm_pkg::*;
#(
  parameter int unsigned D_W          = 8,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned MATRIXSIZE_W = 24
) (
  input  logic                    mm_clk,
  input  logic                    mm_rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_A,
  input  logic [ADDR_W-1:0]       base_B,
  input  logic [MATRIXSIZE_W-1:0] len_A,
  input  logic [MATRIXSIZE_W-1:0] len_B,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [D_W-1:0]          rd_data,
  output logic [D_W-1:0]          out_A_tdata,
  output logic                    out_A_tvalid,
  output logic                    out_A_tlast,
  input  logic                    out_A_tready,
  output logic [D_W-1:0]          out_B_tdata,
  output logic                    out_B_tvalid,
  output logic                    out_B_tlast,
  input  logic                    out_B_tready,
  output logic                    busy,
  output logic                    done
`ifdef MM_SRC_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt_A,
  output logic [31:0]             stall_cnt_B
`endif
);
  localparam int unsigned OCC_W = SRC_FIFO_CNT_W + 1;

  mm_src_state_t             state;
  logic [ADDR_W-1:0]         base_A_q, base_B_q, cur_base;
  logic [MATRIXSIZE_W-1:0]   len_A_q, len_B_q, cur_len;
  logic [MATRIXSIZE_W-1:0]   issued, accepted;
  logic                      inflight, inflight_last;
  logic                      sending_A, sending_B, head_valid, beat_acc, last_acc;
  logic [D_W:0]              fifo_head;
  logic [SRC_FIFO_CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]          occupancy;

  mm_src_fifo #(.W(D_W + 1)) u_fifo (
    .clk       (mm_clk),
    .rst_n     (mm_rst_n),
    .push      (inflight),
    .push_data ({inflight_last, rd_data}),
    .pop       (beat_acc),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    sending_A    = (state == SEND_A);
    sending_B    = (state == SEND_B);
    cur_base     = sending_B ? base_B_q : base_A_q;
    cur_len      = sending_B ? len_B_q : len_A_q;
    head_valid   = (fifo_count != '0);
    out_A_tvalid = sending_A && head_valid;
    out_B_tvalid = sending_B && head_valid;
    out_A_tdata  = out_A_tvalid ? fifo_head[D_W-1:0] : '0;
    out_B_tdata  = out_B_tvalid ? fifo_head[D_W-1:0] : '0;
    out_A_tlast  = out_A_tvalid && fifo_head[D_W];
    out_B_tlast  = out_B_tvalid && fifo_head[D_W];
    beat_acc     = (out_A_tvalid && out_A_tready) || (out_B_tvalid && out_B_tready);
    last_acc     = beat_acc && ((accepted + MATRIXSIZE_W'(1)) == cur_len);
    // Reads in flight count against FIFO space so a stalled stream never overflows it.
    occupancy    = OCC_W'(fifo_count) + OCC_W'(inflight);
    rd_en        = (sending_A || sending_B) && (issued < cur_len)
                   && (occupancy < OCC_W'(SRC_FIFO_DEPTH));
    rd_addr      = rd_en ? cur_base + ADDR_W'(issued) : '0;
  end

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      state         <= IDLE;
      base_A_q      <= '0;
      base_B_q      <= '0;
      len_A_q       <= '0;
      len_B_q       <= '0;
      issued        <= '0;
      accepted      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (issued == cur_len - MATRIXSIZE_W'(1));
      if (rd_en) issued <= issued + MATRIXSIZE_W'(1);
      if (beat_acc) accepted <= accepted + MATRIXSIZE_W'(1);
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          base_A_q <= base_A;
          base_B_q <= base_B;
          len_A_q  <= len_A;
          len_B_q  <= len_B;
          issued   <= '0;
          accepted <= '0;
          busy     <= 1'b1;
          if (len_A != '0)      state <= SEND_A;
          else if (len_B != '0) state <= SEND_B;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SEND_A: if (last_acc) begin
          issued   <= '0;
          accepted <= '0;
          if (len_B_q != '0) state <= SEND_B;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SEND_B: if (last_acc) begin
          issued   <= '0;
          accepted <= '0;
          state    <= DONE;
          done     <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MM_SRC_STALL_CNT_EN
  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      stall_cnt_A <= '0;
      stall_cnt_B <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt_A <= '0;
      stall_cnt_B <= '0;
    end else begin
      if (out_A_tvalid && !out_A_tready && stall_cnt_A != '1) stall_cnt_A <= stall_cnt_A + 32'd1;
      if (out_B_tvalid && !out_B_tready && stall_cnt_B != '1) stall_cnt_B <= stall_cnt_B + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mm_src.sv
// Directed bench for mm_src: RAM model, negedge event monitor, linear checked scenarios.
module tb_mm_src;
  localparam int unsigned D_W    = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned MW     = 24;

  logic              mm_clk, mm_rst_n, start;
  logic [ADDR_W-1:0] base_A, base_B, rd_addr;
  logic [MW-1:0]     len_A, len_B;
  logic              rd_en;
  logic [D_W-1:0]    rd_data, out_A_tdata, out_B_tdata;
  logic              out_A_tvalid, out_A_tlast, out_A_tready;
  logic              out_B_tvalid, out_B_tlast, out_B_tready;
  logic              busy, done;
`ifdef MM_SRC_STALL_CNT_EN
  logic [31:0]       stall_cnt_A, stall_cnt_B;
`endif

  mm_src #(.D_W(D_W), .ADDR_W(ADDR_W), .MATRIXSIZE_W(MW)) dut (
    .mm_clk(mm_clk), .mm_rst_n(mm_rst_n), .start(start),
    .base_A(base_A), .base_B(base_B), .len_A(len_A), .len_B(len_B),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_A_tdata(out_A_tdata), .out_A_tvalid(out_A_tvalid),
    .out_A_tlast(out_A_tlast), .out_A_tready(out_A_tready),
    .out_B_tdata(out_B_tdata), .out_B_tvalid(out_B_tvalid),
    .out_B_tlast(out_B_tlast), .out_B_tready(out_B_tready),
    .busy(busy), .done(done)
`ifdef MM_SRC_STALL_CNT_EN
    , .stall_cnt_A(stall_cnt_A), .stall_cnt_B(stall_cnt_B)
`endif
  );

  logic [D_W-1:0] ram [0:(1<<ADDR_W)-1];
  always_ff @(posedge mm_clk) if (rd_en) rd_data <= ram[rd_addr];

  initial begin
    mm_clk = 1'b0;
    forever #5 mm_clk = ~mm_clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge mm_clk);
    cyc++;
  end

  logic [D_W-1:0]    qa_d[$], qb_d[$];
  bit                qa_l[$], qb_l[$];
  int                qa_c[$], qb_c[$], q_rdc[$];
  logic [ADDR_W-1:0] q_addr[$];
  int done_cnt = 0, done_cyc = -1, busy_cnt = 0, tva_cnt = 0, tvb_cnt = 0;
  int hold_viol = 0, idle_viol = 0, stall_a = 0, max_out = 0, rd_tot = 0, acc_tot = 0, outst;
  bit pv_a = 0, pv_b = 0, pl_a, pl_b;
  logic [D_W-1:0] pd_a, pd_b;

  // Per-cycle event capture, sampled mid-cycle.
  initial forever begin
    @(negedge mm_clk);
    if (!mm_rst_n) begin
      pv_a = 0; pv_b = 0; rd_tot = 0; acc_tot = 0;
    end else begin
      outst = rd_tot + int'(rd_en) - acc_tot;
      if (outst > max_out) max_out = outst;
      if (rd_en) begin q_addr.push_back(rd_addr); q_rdc.push_back(cyc); rd_tot++; end
      if (out_A_tvalid) tva_cnt++;
      if (out_B_tvalid) tvb_cnt++;
      if (out_A_tvalid && out_B_tvalid) idle_viol++;
      if (!out_A_tvalid && (out_A_tdata != 0 || out_A_tlast)) idle_viol++;
      if (!out_B_tvalid && (out_B_tdata != 0 || out_B_tlast)) idle_viol++;
      if (pv_a && !(out_A_tvalid && out_A_tdata == pd_a && out_A_tlast == pl_a)) hold_viol++;
      if (pv_b && !(out_B_tvalid && out_B_tdata == pd_b && out_B_tlast == pl_b)) hold_viol++;
      pv_a = out_A_tvalid && !out_A_tready; pd_a = out_A_tdata; pl_a = out_A_tlast;
      pv_b = out_B_tvalid && !out_B_tready; pd_b = out_B_tdata; pl_b = out_B_tlast;
      if (out_A_tvalid && out_A_tready) begin
        qa_d.push_back(out_A_tdata); qa_l.push_back(out_A_tlast); qa_c.push_back(cyc); acc_tot++;
      end
      if (out_B_tvalid && out_B_tready) begin
        qb_d.push_back(out_B_tdata); qb_l.push_back(out_B_tlast); qb_c.push_back(cyc); acc_tot++;
      end
      if (out_A_tvalid && !out_A_tready) stall_a++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mm_clk);
    #1;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                            input logic [MW-1:0] la, input logic [MW-1:0] lb, output int s);
    base_A = ba; base_B = bb; len_A = la; len_B = lb;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int snap, input int maxc, input string tag);
    for (int k = 0; k < maxc && done_cnt == snap; k++) tick();
    chk(tag, done_cnt > snap, 1);
  endtask

  int s, ia, ib, ir, dsnap, bsnap, tasnap, tbsnap, ssnap, a_last_cyc;

  initial begin
    mm_rst_n = 1'b0; start = 1'b0; base_A = '0; base_B = '0; len_A = '0; len_B = '0;
    out_A_tready = 1'b1; out_B_tready = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) ram[12'h010 + i] = 8'(i + 1);
    ram[12'h020] = 8'd5; ram[12'h021] = 8'd6; ram[12'h022] = 8'd7;
    ram[12'h040] = 8'hFF; ram[12'h041] = 8'hFE;
    for (int i = 0; i < 8; i++) ram[12'h100 + i] = 8'(8'h11 + i);
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hA2; ram[12'h000] = 8'hA3; ram[12'h001] = 8'hA4;
    for (int i = 0; i < 6; i++) ram[12'h200 + i] = 8'(8'h31 + i);

    repeat (3) tick();
    chk("rst_tvalid_A", out_A_tvalid, 0);
    chk("rst_tvalid_B", out_B_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_tdata_A", out_A_tdata, 0);
    mm_rst_n = 1'b1;
    tick();

    // Basic A only
    ia = qa_d.size(); ir = q_addr.size(); dsnap = done_cnt; tbsnap = tvb_cnt;
    start_xfer(12'h010, 12'h000, 4, 0, s);
    wait_done(dsnap, 40, "basicA_timeout");
    tick(); tick();
    chk("basicA_first_rd_cyc", q_rdc[ir], s + 1);
    chk("basicA_beats", qa_d.size() - ia, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basicA_data%0d", i), qa_d[ia + i], i + 1);
      chk($sformatf("basicA_last%0d", i), qa_l[ia + i], i == 3);
      chk($sformatf("basicA_cyc%0d", i), qa_c[ia + i], s + 3 + i);
    end
    chk("basicA_done_cyc", done_cyc, s + 7);
    chk("basicA_done_cnt", done_cnt - dsnap, 1);
    chk("basicA_no_B", tvb_cnt - tbsnap, 0);

    // A then B
    ia = qa_d.size(); ib = qb_d.size(); dsnap = done_cnt;
    start_xfer(12'h020, 12'h040, 3, 2, s);
    wait_done(dsnap, 40, "ab_timeout");
    tick(); tick();
    chk("ab_A_beats", qa_d.size() - ia, 3);
    chk("ab_B_beats", qb_d.size() - ib, 2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ab_A_data%0d", i), qa_d[ia + i], 5 + i);
      chk($sformatf("ab_A_last%0d", i), qa_l[ia + i], i == 2);
    end
    chk("ab_B_data0", qb_d[ib], 8'hFF);
    chk("ab_B_data1", qb_d[ib + 1], 8'hFE);
    chk("ab_B_last0", qb_l[ib], 0);
    chk("ab_B_last1", qb_l[ib + 1], 1);
    a_last_cyc = qa_c[ia + 2];
    chk("ab_B_first_cyc", qb_c[ib], a_last_cyc + 3);
    chk("ab_done_cnt", done_cnt - dsnap, 1);

    // Backpressure on A: ready pattern 1,0,0 repeating
    ia = qa_d.size(); dsnap = done_cnt; ssnap = stall_a;
    start_xfer(12'h100, 12'h000, 8, 0, s);
    for (int k = 1; k < 100 && done_cnt == dsnap; k++) begin
      out_A_tready = (k % 3 == 0);
      tick();
    end
    out_A_tready = 1'b1;
    chk("bp_timeout", done_cnt > dsnap, 1);
    tick();
    chk("bp_beats", qa_d.size() - ia, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_data%0d", i), qa_d[ia + i], 8'h11 + i);
      chk($sformatf("bp_last%0d", i), qa_l[ia + i], i == 7);
    end
    chk("bp_stalls_seen", (stall_a - ssnap) > 0, 1);
    chk("bp_hold", hold_viol, 0);
    chk("bp_outstanding_le3", max_out <= 3, 1);
`ifdef MM_SRC_STALL_CNT_EN
    chk("bp_stall_cnt_A", stall_cnt_A, stall_a - ssnap);
    chk("bp_stall_cnt_B", stall_cnt_B, 0);
`endif

    // Zero lengths
    dsnap = done_cnt; bsnap = busy_cnt; tasnap = tva_cnt; tbsnap = tvb_cnt; ir = q_addr.size();
    start_xfer(12'h000, 12'h000, 0, 0, s);
    repeat (4) tick();
    chk("zero_done_cnt", done_cnt - dsnap, 1);
    chk("zero_done_cyc", done_cyc, s + 1);
    chk("zero_busy_cycles", busy_cnt - bsnap, 1);
    chk("zero_no_tvalid_A", tva_cnt - tasnap, 0);
    chk("zero_no_tvalid_B", tvb_cnt - tbsnap, 0);
    chk("zero_no_reads", q_addr.size() - ir, 0);

    // Address wrap, second start ignored
    ia = qa_d.size(); ir = q_addr.size(); dsnap = done_cnt;
    start_xfer(12'hFFE, 12'h000, 4, 0, s);
    base_A = 12'h010; len_A = 2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dsnap, 40, "wrap_timeout");
    repeat (5) tick();
    chk("wrap_reads", q_addr.size() - ir, 4);
    chk("wrap_addr0", q_addr[ir], 12'hFFE);
    chk("wrap_addr1", q_addr[ir + 1], 12'hFFF);
    chk("wrap_addr2", q_addr[ir + 2], 12'h000);
    chk("wrap_addr3", q_addr[ir + 3], 12'h001);
    chk("wrap_beats", qa_d.size() - ia, 4);
    chk("wrap_data0", qa_d[ia], 8'hA1);
    chk("wrap_data3", qa_d[ia + 3], 8'hA4);
    chk("wrap_done_cnt", done_cnt - dsnap, 1);

    // Reset during the second A beat, then a clean restart
    start_xfer(12'h200, 12'h000, 6, 0, s);
    repeat (3) tick();
    chk("rstmid_pre_tvalid", out_A_tvalid, 1);
    chk("rstmid_pre_data", out_A_tdata, 8'h32);
    mm_rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", out_A_tvalid, 0);
    chk("rstmid_tlast", out_A_tlast, 0);
    chk("rstmid_busy", busy, 0);
    tick(); tick();
    mm_rst_n = 1'b1;
    tick();
    ia = qa_d.size(); dsnap = done_cnt;
    start_xfer(12'h200, 12'h000, 6, 0, s);
    wait_done(dsnap, 40, "rstmid_restart_timeout");
    tick();
    chk("rstmid_beats", qa_d.size() - ia, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rstmid_data%0d", i), qa_d[ia + i], 8'h31 + i);
    chk("rstmid_last5", qa_l[ia + 5], 1);

    chk("idle_channels_quiet", idle_viol, 0);
    chk("hold_total", hold_viol, 0);
    chk("outstanding_total_le3", max_out <= 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
